bo_bc_mult: RTL and testbench

Parametrised sequential shift-add multiplier that combines its own operative block (registers and adder) and control FSM. It is the W-bit successor of the fixed control-unit FSM in this codebase: the FSM now runs its own iteration counter and exposes a start/busy/done handshake. Product width is 2W. It sits between the stimulus/control layer (INICIO) and any consumer of the product.

---
 rtl/bo_bc_mult.sv | 135 +++++++++++++
 tb/tb_bo_bc_mult.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bo_bc_mult.sv
// bo_bc_mult: W-bit sequential shift-add multiplier with start/busy/done handshake.
// Operand registers, accumulator and iteration counter sit alongside a
// three-state control FSM (IDLE -> CALC -> DONE). The product is 2W bits wide.
// Optional feature: define MULT_ABORT_EN to add the ABORTA input, which sends
// the FSM back to IDLE from CALC or DONE.
module bo_bc_mult #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           INICIO,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
`ifdef MULT_ABORT_EN
   input  logic           ABORTA,
`endif
   output logic [2*W-1:0] P,
   output logic           OCUPADO,
   output logic           PRONTO
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [W-1:0]     md_r;
   logic [2*W-1:0]   acc_r;
   logic [CW-1:0]    cnt_r;
   logic [W:0]       sum_s;
   logic [2*W-1:0]   acc_shift_s;
   logic             abort_s;

`ifdef MULT_ABORT_EN
   assign abort_s = ABORTA;
`else
   assign abort_s = 1'b0;
`endif

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; abort outranks INICIO, and DONE waits for INICIO to drop.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (INICIO) begin
               state_nx_s = CALC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            if (abort_s) begin
               state_nx_s = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = CALC;
            end
         end
         DONE: begin
            if (abort_s) begin
               state_nx_s = IDLE;
            end else if (INICIO) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // One shift-add iteration; the carry of the upper-half add lands in the
   // sum MSB and becomes the accumulator MSB after the right shift.
   always_comb begin
      sum_s       = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, md_r} : {(W+1){1'b0}});
      acc_shift_s = {sum_s, acc_r[W-1:1]};
   end

   // Datapath registers and handshake outputs, all decoded from the next state
   // so OCUPADO/PRONTO are glitch-free flops aligned with the FSM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         md_r    <= {W{1'b0}};
         acc_r   <= {(2*W){1'b0}};
         cnt_r   <= {CW{1'b0}};
         P       <= {(2*W){1'b0}};
         OCUPADO <= 1'b0;
         PRONTO  <= 1'b0;
      end else begin
         OCUPADO <= (state_nx_s == CALC);
         PRONTO  <= (state_nx_s == DONE);
         case (state_r)
            IDLE: begin
               if (INICIO) begin
                  md_r  <= A;
                  acc_r <= {{W{1'b0}}, B};
                  cnt_r <= {CW{1'b0}};
               end
            end
            CALC: begin
               if (!abort_s) begin
                  acc_r <= acc_shift_s;
                  cnt_r <= cnt_r + CNT_ONE;
                  if (cnt_r == CNT_LAST) begin
                     P <= acc_shift_s;
                  end
               end
            end
            default: begin
               md_r <= md_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bo_bc_mult.sv
// Self-checking bench for bo_bc_mult (W=8). The reference is plain integer
// multiplication plus the handshake timing: OCUPADO for W cycles after the
// start edge, PRONTO with the product on edge e0+W, P held otherwise.
module tb_bo_bc_mult;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           INICIO;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-1:0] P;
   logic           OCUPADO;
   logic           PRONTO;
`ifdef MULT_ABORT_EN
   logic           ABORTA;
`endif

   int             total  = 0;
   int             passed = 0;
   logic [2*W-1:0] model_p;

   always #5 clk = ~clk;

   bo_bc_mult #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .INICIO  (INICIO),
      .A       (A),
      .B       (B),
`ifdef MULT_ABORT_EN
      .ABORTA  (ABORTA),
`endif
      .P       (P),
      .OCUPADO (OCUPADO),
      .PRONTO  (PRONTO)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation; hold = extra cycles INICIO stays high in DONE.
   // Operand inputs are scrambled mid-CALC to prove capture at start.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [2*W-1:0] expp;
      expp   = 16'(int'(a) * int'(b));
      A      = a;
      B      = b;
      INICIO = 1'b1;
      tick();
      check("e0_busy", OCUPADO, 64'd1);
      check("e0_done", PRONTO, 64'd0);
      if (hold == 0) INICIO = 1'b0;
      for (int k = 1; k < W; k++) begin
         if (k == 3) begin
            A = W'($urandom);
            B = W'($urandom);
         end
         tick();
         check("calc_busy", OCUPADO, 64'd1);
         check("calc_p_hold", P, 64'(model_p));
      end
      tick();
      check("fin_busy", OCUPADO, 64'd0);
      check("fin_done", PRONTO, 64'd1);
      check("fin_p", P, 64'(expp));
      model_p = expp;
      for (int k = 0; k < hold; k++) begin
         tick();
      end
      if (hold > 0) begin
         check("held_done", PRONTO, 64'd1);
         check("held_busy", OCUPADO, 64'd0);
         check("held_p", P, 64'(expp));
      end
      INICIO = 1'b0;
      tick();
      check("idle_done", PRONTO, 64'd0);
      check("idle_busy", OCUPADO, 64'd0);
      check("idle_p", P, 64'(expp));
   endtask

   initial begin
      model_p = 16'd0;
      rst     = 1'b0;
      INICIO  = 1'b1;
      A       = W'($urandom);
      B       = W'($urandom);
`ifdef MULT_ABORT_EN
      ABORTA  = 1'b1;
`endif
      tick();
      check("rst_p", P, 64'd0);
      check("rst_busy", OCUPADO, 64'd0);
      check("rst_done", PRONTO, 64'd0);
      rst    = 1'b1;
      INICIO = 1'b0;
`ifdef MULT_ABORT_EN
      ABORTA = 1'b0;
`endif
      tick();
      check("idle_after_rst", OCUPADO, 64'd0);

      // directed products and boundaries
      run_op(8'd13, 8'd11, 0);
      tick();
      check("hold143", P, 64'd143);
      run_op(8'd255, 8'd255, 0);
      check("carry_fe01", P, 64'd65025);
      run_op(8'd0, 8'd200, 20 - (W + 1));
      run_op(8'd1, 8'd255, 0);
      run_op(8'd128, 8'd2, 0);
      run_op(8'd255, 8'd0, 0);

      // randomized products
      for (int i = 0; i < 12; i++) begin
         run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end

      // reset during CALC cycle 4
      A      = 8'd77;
      B      = 8'd99;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("pre_rst_busy", OCUPADO, 64'd1);
      rst = 1'b0;
      tick();
      check("midrst_p", P, 64'd0);
      check("midrst_busy", OCUPADO, 64'd0);
      check("midrst_done", PRONTO, 64'd0);
      model_p = 16'd0;
      rst = 1'b1;
      tick();
      run_op(8'd77, 8'd99, 0);

`ifdef MULT_ABORT_EN
      run_op(8'd13, 8'd11, 0);
      // abort in CALC cycle 3
      A      = 8'd7;
      B      = 8'd9;
      INICIO = 1'b1;
      tick();
      INICIO = 1'b0;
      tick();
      tick();
      ABORTA = 1'b1;
      tick();
      ABORTA = 1'b0;
      check("abort_busy", OCUPADO, 64'd0);
      check("abort_done", PRONTO, 64'd0);
      check("abort_p", P, 64'd143);
      for (int k = 0; k < W; k++) tick();
      check("abort_no_done", PRONTO, 64'd0);
      check("abort_p_kept", P, 64'd143);
      // abort in IDLE is ignored
      ABORTA = 1'b1;
      tick();
      ABORTA = 1'b0;
      check("idle_abort_p", P, 64'd143);
      run_op(8'd7, 8'd9, 0);
      // abort in DONE drops PRONTO, keeps new product
      A      = 8'd21;
      B      = 8'd3;
      INICIO = 1'b1;
      for (int k = 0; k <= W; k++) tick();
      check("pre_done_abort", PRONTO, 64'd1);
      ABORTA = 1'b1;
      tick();
      ABORTA = 1'b0;
      INICIO = 1'b0;
      check("done_abort_done", PRONTO, 64'd0);
      check("done_abort_p", P, 64'd63);
      model_p = 16'd63;
      tick();
      run_op(8'd5, 8'd6, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
